// File: rtl/sign_narrow_unit.sv
// Signed IN_W -> OUT_W narrowing with overflow detect, truncate/saturate and a 2-entry output FIFO.
// Optional macro SIGN_NARROW_CNT_EN adds the saturating overflow event counter (ovf_count).
module sign_narrow_unit #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             sat_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, state_nxt;
    logic               accept, deliver;
    logic               ovf;
    logic [OUT_W-1:0]   narrow;
    logic [IN_W-OUT_W:0] top_bits;
    logic [OUT_W-1:0]   head_data, tail_data;
    logic               head_ovf, tail_ovf;

    // The value fits iff every bit from the OUT_W sign position upward agrees.
    assign top_bits = in_data[IN_W-1:OUT_W-1];

    always_comb begin
        ovf    = !((&top_bits) || !(|top_bits));
        narrow = in_data[OUT_W-1:0];
        if (ovf && sat_mode) begin
            narrow = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    assign accept = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !deliver)      state_nxt = TWO;
                else if (!accept && deliver) state_nxt = EMPTY;
            end
            TWO:     if (deliver) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
    end

    // Head register drives the outputs directly; tail only fills when the head is occupied and held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            head_ovf  <= 1'b0;
            tail_data <= '0;
            tail_ovf  <= 1'b0;
        end else begin
            if (accept && (state == EMPTY || (state == ONE && deliver))) begin
                head_data <= narrow;
                head_ovf  <= ovf;
            end else if (deliver && state == TWO) begin
                head_data <= tail_data;
                head_ovf  <= tail_ovf;
            end
            if (accept && state == ONE && !deliver) begin
                tail_data <= narrow;
                tail_ovf  <= ovf;
            end
        end
    end

    assign out_data = head_data;
    assign out_ovf  = head_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                sticky_ovf <= 1'b0;
        else if (accept && ovf)    sticky_ovf <= 1'b1;
        else if (clr_sticky)       sticky_ovf <= 1'b0;
    end

`ifdef SIGN_NARROW_CNT_EN
    logic [CNT_W-1:0] cnt;

    // A clear coinciding with an overflowing accept restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept && ovf) begin
            if (clr_sticky)  cnt <= CNT_W'(1);
            else if (!(&cnt)) cnt <= cnt + CNT_W'(1);
        end else if (clr_sticky) begin
            cnt <= '0;
        end
    end

    assign ovf_count = cnt;
`else
    assign ovf_count = '0;
`endif

endmodule
